// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bus of the branch predict unit.
//   master : pipeline side, drives fetch_pc and the ex_* execute-stage fields and
//            receives the prediction, redirect and status outputs.
//   slave  : predictor side (branch_predict_unit).
interface branch_predict_unit_if #(
  parameter int unsigned PC_WIDTH  = 9,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [PC_WIDTH-1:0]  fetch_pc;
  logic                 pred_taken;
  logic [PC_WIDTH-1:0]  pred_target;
  logic                 ex_valid;
  logic [PC_WIDTH-1:0]  ex_pc;
  logic [31:0]          ex_imm;
  logic                 ex_branch;
  logic                 ex_jump;
  logic                 ex_cond;
  logic                 ex_pred_taken;
  logic [PC_WIDTH-1:0]  ex_pred_target;
  logic                 ex_halt;
  logic                 pc_sel;
  logic [PC_WIDTH-1:0]  pc_redirect;
  logic                 flush;
  logic                 halted;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_cond,
           ex_pred_taken, ex_pred_target, ex_halt,
    input  pred_taken, pred_target, pc_sel, pc_redirect, flush, halted, mispredict_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_cond,
           ex_pred_taken, ex_pred_target, ex_halt,
    output pred_taken, pred_target, pc_sel, pc_redirect, flush, halted, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, execute-stage
// misprediction detection/redirect, misprediction counter and a sticky halt state.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : branch_predict_unit_if.slave -- fetch lookup (fetch_pc -> pred_taken,
//            pred_target), execute resolution (ex_*), redirect (pc_sel, pc_redirect,
//            flush), status (halted, mispredict_count)
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH    = 9,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned Idx  = $clog2(BHT_ENTRIES);
  localparam int unsigned TagW = PC_WIDTH - Idx - 2;

  typedef enum logic {StRun, StHalted} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    halt_pc_q, halt_pc_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

  logic [BHT_ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]        tag_q [BHT_ENTRIES];
  logic [TagW-1:0]        tag_d [BHT_ENTRIES];
  logic [PC_WIDTH-1:0]    tgt_q [BHT_ENTRIES];
  logic [PC_WIDTH-1:0]    tgt_d [BHT_ENTRIES];
  logic [1:0]             cnt_q [BHT_ENTRIES];
  logic [1:0]             cnt_d [BHT_ENTRIES];

  logic [Idx-1:0]         f_idx, e_idx;
  logic [TagW-1:0]        f_tag, e_tag;
  logic [PC_WIDTH-1:0]    target, seq;
  logic                   actual_taken, run_eff, mispredict, do_update, e_hit;
  logic [1:0]             cnt_new;
  logic                   unused_imm;

  assign unused_imm = ^bus.ex_imm[31:PC_WIDTH];

  // Fetch lookup reads the registered table only, so a same-cycle update is not visible.
  assign f_idx = bus.fetch_pc[Idx+1:2];
  assign f_tag = bus.fetch_pc[PC_WIDTH-1:Idx+2];
  assign bus.pred_taken  = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && cnt_q[f_idx][1];
  assign bus.pred_target = bus.pred_taken ? tgt_q[f_idx] : bus.fetch_pc + PC_WIDTH'(4);

  assign e_idx        = bus.ex_pc[Idx+1:2];
  assign e_tag        = bus.ex_pc[PC_WIDTH-1:Idx+2];
  assign e_hit        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign actual_taken = (bus.ex_branch & bus.ex_cond) | bus.ex_jump;
  assign target       = bus.ex_pc + bus.ex_imm[PC_WIDTH-1:0];
  assign seq          = bus.ex_pc + PC_WIDTH'(4);

  // While reset is held the outputs behave as in RUN regardless of the halt state.
  assign run_eff    = reset || (state_q == StRun);
  assign mispredict = bus.ex_valid && run_eff && !bus.ex_halt &&
                      ((actual_taken != bus.ex_pred_taken) ||
                       (actual_taken && (bus.ex_pred_target != target)));
  assign do_update  = bus.ex_valid && run_eff && !bus.ex_halt &&
                      (bus.ex_branch || bus.ex_jump);

  assign bus.halted           = (state_q == StHalted);
  assign bus.mispredict_count = miss_cnt_q;

  // Counter value written on an update.
  always_comb begin
    cnt_new = cnt_q[e_idx];
    if (bus.ex_jump) begin
      cnt_new = 2'b11;
    end else if (!e_hit) begin
      cnt_new = actual_taken ? 2'b10 : 2'b01;
    end else if (actual_taken) begin
      cnt_new = (cnt_q[e_idx] == 2'b11) ? 2'b11 : cnt_q[e_idx] + 2'b01;
    end else begin
      cnt_new = (cnt_q[e_idx] == 2'b00) ? 2'b00 : cnt_q[e_idx] - 2'b01;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (do_update) begin
      valid_d[e_idx] = 1'b1;
      tag_d[e_idx]   = e_tag;
      tgt_d[e_idx]   = target;
      cnt_d[e_idx]   = cnt_new;
    end
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (mispredict && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Halt FSM and redirect outputs.
  always_comb begin
    state_d         = state_q;
    halt_pc_d       = halt_pc_q;
    bus.pc_sel      = 1'b0;
    bus.flush       = 1'b0;
    bus.pc_redirect = seq;
    if (!run_eff) begin
      bus.pc_sel      = 1'b1;
      bus.flush       = 1'b1;
      bus.pc_redirect = halt_pc_q;
    end else if (bus.ex_valid && bus.ex_halt) begin
      bus.pc_sel      = 1'b1;
      bus.flush       = 1'b1;
      bus.pc_redirect = bus.ex_pc;
      state_d         = StHalted;
      halt_pc_d       = bus.ex_pc;
    end else if (mispredict) begin
      bus.pc_sel      = 1'b1;
      bus.flush       = 1'b1;
      bus.pc_redirect = actual_taken ? target : seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      halt_pc_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else begin
      state_q    <= state_d;
      halt_pc_q  <= halt_pc_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
